// File: rtl/slot_alloc_encoder.sv
// Stateful slot allocator: tracks a busy bitmap and grants one free slot per cycle,
// either lowest-index-first or round-robin after the last granted slot.
module slot_alloc_encoder #(
  parameter int unsigned NUM_SLOTS = 40,
  parameter int unsigned IDX_W     = 6,
  parameter int unsigned RR_MODE   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alloc_req,
  output logic                 alloc_valid,
  output logic [IDX_W-1:0]     alloc_idx,
  input  logic                 free_en,
  input  logic [IDX_W-1:0]     free_idx,
  input  logic                 flush,
  output logic                 full,
  output logic [IDX_W:0]       free_count,
  output logic [NUM_SLOTS-1:0] busy_mask
);

  localparam int unsigned CntW = IDX_W + 1;

  logic [NUM_SLOTS-1:0] busy_q, busy_d;
  logic [CntW-1:0]      free_count_q, free_count_d;
  logic                 alloc_valid_q;
  logic [IDX_W-1:0]     alloc_idx_q;
  logic [IDX_W-1:0]     rr_ptr_q;

  logic [IDX_W-1:0]     sel_idx;
  logic [NUM_SLOTS-1:0] grant_mask;
  logic [NUM_SLOTS-1:0] free_mask;
  logic                 grant;
  logic                 free_hit;

  assign full = (free_count_q == '0);

  // Selection looks only at the registered busy map; a slot freed this cycle is not seen.
  always_comb begin
    sel_idx = '0;
    if (RR_MODE == 0) begin
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
        if (!busy_q[i]) sel_idx = IDX_W'(i);
      end
    end else begin
      // Walk offsets from farthest to nearest so the nearest free slot after rr_ptr wins.
      for (int k = NUM_SLOTS; k >= 1; k--) begin
        int unsigned j;
        j = (32'(rr_ptr_q) + 32'(k)) % NUM_SLOTS;
        if (!busy_q[j]) sel_idx = IDX_W'(j);
      end
    end
  end

  always_comb begin
    grant      = alloc_req && !full && !flush;
    grant_mask = '0;
    free_mask  = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (grant && (sel_idx == IDX_W'(i))) grant_mask[i] = 1'b1;
      // Out-of-range indices never match; already-free slots are filtered by busy_q.
      if (free_en && !flush && (free_idx == IDX_W'(i)) && busy_q[i]) free_mask[i] = 1'b1;
    end
    free_hit = |free_mask;

    if (flush) begin
      busy_d       = '0;
      free_count_d = CntW'(NUM_SLOTS);
    end else begin
      busy_d       = (busy_q & ~free_mask) | grant_mask;
      free_count_d = free_count_q - {{IDX_W{1'b0}}, grant} + {{IDX_W{1'b0}}, free_hit};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q        <= '0;
      free_count_q  <= CntW'(NUM_SLOTS);
      alloc_valid_q <= 1'b0;
      alloc_idx_q   <= '0;
      rr_ptr_q      <= '0;
    end else begin
      busy_q        <= busy_d;
      free_count_q  <= free_count_d;
      alloc_valid_q <= grant;
      if (grant) begin
        alloc_idx_q <= sel_idx;
        rr_ptr_q    <= sel_idx;
      end
    end
  end

  assign alloc_valid = alloc_valid_q;
  assign alloc_idx   = alloc_idx_q;
  assign free_count  = free_count_q;
  assign busy_mask   = busy_q;

endmodule
